// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-atomic arbiter that shares one fifo write port between NUM_REQ producers.
// The owning lane keeps the port until its last beat is written; fifo back-pressure is honoured.
module fifo_write_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_BITS = 2,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_space,
    output logic [WIDTH-1:0]           fifo_wdata,
    output logic                       fifo_wstrobe,
    output logic                       busy,
    output logic [IDX_BITS-1:0]        grant_idx,
    output logic [CNT_BITS-1:0]        pkt_count
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state;
    logic [IDX_BITS-1:0] ptr;
    logic [IDX_BITS-1:0] cand;
    logic [IDX_BITS-1:0] pick;
    logic [IDX_BITS-1:0] ptr_next;
    logic                found;
    logic                owning;
    logic                accept;

    // First valid lane at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_BITS'((32'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Gating with reset_n keeps the port quiet during reset even while the FSM still holds GRANT.
    assign owning   = (state == StGrant) && reset_n;
    assign accept   = owning && req_valid[grant_idx] && fifo_space;
    assign ptr_next = IDX_BITS'((32'(grant_idx) + 32'd1) % NUM_REQ);

    always_comb begin
        req_ready = '0;
        if (owning) begin
            req_ready[grant_idx] = fifo_space;
        end
    end

    assign fifo_wstrobe = accept;
    assign fifo_wdata   = req_data[32'(grant_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= StIdle;
            busy      <= 1'b0;
            grant_idx <= '0;
            pkt_count <= '0;
            ptr       <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (found) begin
                        state     <= StGrant;
                        busy      <= 1'b1;
                        grant_idx <= pick;
                    end
                end
                StGrant: begin
                    if (accept && req_last[grant_idx]) begin
                        state     <= StIdle;
                        busy      <= 1'b0;
                        ptr       <= ptr_next;
                        pkt_count <= pkt_count + CNT_BITS'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: queue-driven producers, a per-cycle
// behavioural model of ownership/rotation, and directed scenarios with literal expectations.
module tb_fifo_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_space;
    logic [W-1:0]   fifo_wdata;
    logic           fifo_wstrobe;
    logic           busy;
    logic [1:0]     grant_idx;
    logic [15:0]    pkt_count;

    fifo_write_arbiter #(
        .WIDTH    (8),
        .NUM_REQ  (4),
        .IDX_BITS (2),
        .CNT_BITS (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_space   (fifo_space),
        .fifo_wdata   (fifo_wdata),
        .fifo_wstrobe (fifo_wstrobe),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         last;
        int         gap;
    } beat_t;

    beat_t      lq[N][$];
    bit         pres[N];
    int         gap_left[N];
    bit         lane_acc[N];
    bit         hold_lanes;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    int         gnt_log[$];
    logic [7:0] exp_w[$];
    int         vld_cyc;
    bit         busy_prev;
    int         drop_s;
    int         drop_r;

    // model state
    bit          model_ok = 0;
    int          m_owner;
    int          m_ptr;
    logic [15:0] m_cnt;
    logic [3:0]  e_ready;
    logic        e_strobe;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wc(int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -999;
    endfunction

    function automatic int gn(int i);
        return (i < gnt_log.size()) ? gnt_log[i] : -1;
    endfunction

    function automatic logic [7:0] wd(int i);
        return (i < wr_log.size()) ? wr_log[i] : 8'hxx;
    endfunction

    function automatic void push(int lane, logic [7:0] d, bit last, int gap);
        beat_t b;
        b.d = d;
        b.last = last;
        b.gap = gap;
        lq[lane].push_back(b);
    endfunction

    function automatic bit lanes_empty();
        for (int i = 0; i < N; i++) begin
            if (lq[i].size() != 0 || pres[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            lq[i].delete();
            pres[i] = 1'b0;
            gap_left[i] = 0;
        end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        gnt_log.delete();
        vld_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        hold_lanes = 1'b1;
        flush();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold_lanes = 1'b0;
        clear_logs();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk); #1;
            n++;
            done = lanes_empty() && (busy === 1'b0) && (req_valid == '0);
        end
        check({name, " idle timeout"}, 64'(done), 64'd1);
    endtask

    task automatic wait_writes(input string name, input int cnt, input int budget);
        int n = 0;
        while (wr_log.size() < cnt && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, " write timeout"}, 64'(wr_log.size() >= cnt), 64'd1);
    endtask

    task automatic check_writes(input string name);
        check({name, " nwrites"}, 64'(wr_log.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++) begin
            check($sformatf("%s wdata[%0d]", name, i), 64'(wd(i)), 64'(exp_w[i]));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    // Producers: present the head beat, honour gaps, pop on acceptance.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (!hold_lanes) begin
                for (int i = 0; i < N; i++) begin
                    if (lane_acc[i] && lq[i].size() > 0) begin
                        void'(lq[i].pop_front());
                        pres[i] = 1'b0;
                    end
                    if (!pres[i] && lq[i].size() > 0) begin
                        pres[i] = 1'b1;
                        gap_left[i] = lq[i][0].gap;
                    end
                    if (pres[i] && gap_left[i] > 0) begin
                        gap_left[i]--;
                        req_valid[i] = 1'b0;
                    end else if (pres[i]) begin
                        req_valid[i] = 1'b1;
                        req_last[i] = lq[i][0].last;
                        req_data[i*W +: W] = lq[i][0].d;
                    end else begin
                        req_valid[i] = 1'b0;
                        req_last[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: log accepted beats, fifo writes and grant events.
    initial begin
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                lane_acc[i] = (req_valid[i] === 1'b1) && (req_ready[i] === 1'b1);
            end
            if (fifo_wstrobe === 1'b1) begin
                wr_log.push_back(fifo_wdata);
                wr_cyc.push_back(cyc);
            end
            if (busy === 1'b1 && !busy_prev) gnt_log.push_back(int'(grant_idx));
            busy_prev = (busy === 1'b1);
            if (vld_cyc < 0 && req_valid != '0) vld_cyc = cyc;
        end
    end

    // Behavioural model: who owns the port, where the search starts, packets done.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                e_ready  = '0;
                e_strobe = 1'b0;
                if (reset_n && m_owner >= 0) begin
                    e_ready[m_owner] = fifo_space;
                    e_strobe = req_valid[m_owner] && fifo_space;
                end
                check("model ready", 64'(req_ready), 64'(e_ready));
                check("model wstrobe", 64'(fifo_wstrobe), 64'(e_strobe));
                check("model busy", 64'(busy), 64'(m_owner >= 0));
                check("model pkt_count", 64'(pkt_count), 64'(m_cnt));
                if (m_owner >= 0) begin
                    check("model grant_idx", 64'(grant_idx), 64'(m_owner));
                    check("model wdata", 64'(fifo_wdata), 64'(req_data[m_owner*W +: W]));
                end
            end
            @(posedge clk);
            if (!reset_n) begin
                model_ok = 1'b1;
                m_owner  = -1;
                m_ptr    = 0;
                m_cnt    = '0;
            end else if (model_ok) begin
                if (m_owner < 0) begin
                    for (int k = 0; k < N; k++) begin
                        if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                    end
                end else if (req_valid[m_owner] && fifo_space && req_last[m_owner]) begin
                    m_cnt   = m_cnt + 16'd1;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        hold_lanes = 1'b1;
        fifo_space = 1'b1;
        req_data   = '0;
        flush();
        clear_logs();
        for (int i = 0; i < N; i++) lane_acc[i] = 1'b0;

        // 1: reset with every lane requesting
        req_valid = '1;
        req_last  = '1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("t1 ready", 64'(req_ready), 64'd0);
        check("t1 wstrobe", 64'(fifo_wstrobe), 64'd0);
        check("t1 busy", 64'(busy), 64'd0);
        check("t1 pkt_count", 64'(pkt_count), 64'd0);
        @(posedge clk); #1;
        req_valid  = '0;
        req_last   = '0;
        reset_n    = 1'b1;
        hold_lanes = 1'b0;
        clear_logs();

        // 2: lane 2, three beats
        push(2, 8'hA1, 1'b0, 0);
        push(2, 8'hA2, 1'b0, 0);
        push(2, 8'hA3, 1'b1, 0);
        wait_idle("t2", 50);
        exp_w = '{8'hA1, 8'hA2, 8'hA3};
        check_writes("t2");
        check("t2 grant", 64'(gn(0)), 64'd2);
        check("t2 latency", 64'(wc(0) - vld_cyc), 64'd1);
        check("t2 contiguous", 64'(wc(2) - wc(0)), 64'd2);
        check("t2 pkt_count", 64'(pkt_count), 64'd1);

        // 3: round robin with all lanes requesting
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push(i, 8'(8'h30 + 16 * r + i), 1'b1, 0);
        end
        wait_idle("t3", 100);
        exp_w = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43};
        check_writes("t3");
        check("t3 grant0", 64'(gn(0)), 64'd0);
        check("t3 grant1", 64'(gn(1)), 64'd1);
        check("t3 grant2", 64'(gn(2)), 64'd2);
        check("t3 grant3", 64'(gn(3)), 64'd3);
        check("t3 grant4", 64'(gn(4)), 64'd0);
        for (int i = 1; i < 8; i++) check($sformatf("t3 spacing%0d", i), 64'(wc(i) - wc(i-1)), 64'd2);
        check("t3 pkt_count", 64'(pkt_count), 64'd8);

        // 4: atomicity with a valid gap on lane 0 while lane 1 waits
        do_reset();
        push(0, 8'h50, 1'b0, 0);
        push(0, 8'h51, 1'b0, 0);
        push(0, 8'h52, 1'b0, 1);
        push(0, 8'h53, 1'b1, 0);
        push(1, 8'h60, 1'b0, 0);
        push(1, 8'h61, 1'b1, 0);
        wait_idle("t4", 100);
        exp_w = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61};
        check_writes("t4");
        check("t4 grant0", 64'(gn(0)), 64'd0);
        check("t4 grant1", 64'(gn(1)), 64'd1);
        check("t4 span", 64'(wc(3) - wc(0)), 64'd4);
        check("t4 rearb", 64'(wc(4) - wc(3)), 64'd2);
        check("t4 pkt_count", 64'(pkt_count), 64'd2);

        // 5: fifo back-pressure for five cycles mid-packet
        do_reset();
        for (int i = 0; i < 4; i++) push(3, 8'(8'h70 + i), i == 3, 0);
        wait_writes("t5", 2, 50);
        @(posedge clk); #1;
        fifo_space = 1'b0;
        drop_s = 0;
        drop_r = 0;
        repeat (5) begin
            @(negedge clk);
            if (fifo_wstrobe !== 1'b0) drop_s++;
            if (req_ready !== 4'b0) drop_r++;
        end
        check("t5 drop strobes", 64'(drop_s), 64'd0);
        check("t5 drop ready", 64'(drop_r), 64'd0);
        check("t5 writes at drop", 64'(wr_log.size()), 64'd2);
        @(posedge clk); #1;
        fifo_space = 1'b1;
        wait_idle("t5", 50);
        exp_w = '{8'h70, 8'h71, 8'h72, 8'h73};
        check_writes("t5");
        check("t5 resume", 64'(wc(2) - wc(1)), 64'd6);
        check("t5 pkt_count", 64'(pkt_count), 64'd1);

        // 6: reset mid-packet; pointer must restart at lane 0
        do_reset();
        push(2, 8'h7F, 1'b1, 0);
        wait_idle("t6a", 50);
        for (int i = 0; i < 4; i++) push(2, 8'(8'h80 + i), i == 3, 0);
        wait_writes("t6", 3, 50);
        @(posedge clk); #1;
        reset_n = 1'b0;
        hold_lanes = 1'b1;
        flush();
        @(negedge clk); #1;
        check("t6 ready in reset", 64'(req_ready), 64'd0);
        check("t6 wstrobe in reset", 64'(fifo_wstrobe), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        hold_lanes = 1'b0;
        gnt_log.delete();
        @(negedge clk); #1;
        check("t6 busy", 64'(busy), 64'd0);
        check("t6 pkt_count", 64'(pkt_count), 64'd0);
        check("t6 abandoned", 64'(wr_log.size()), 64'd3);
        push(3, 8'h93, 1'b1, 0);
        push(0, 8'h90, 1'b1, 0);
        wait_idle("t6b", 50);
        exp_w = '{8'h7F, 8'h80, 8'h81, 8'h90, 8'h93};
        check_writes("t6");
        check("t6 grant0", 64'(gn(0)), 64'd0);
        check("t6 grant1", 64'(gn(1)), 64'd3);
        check("t6 pkt_final", 64'(pkt_count), 64'd2);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
